bug_spawn_gen: RTL and testbench

Generates bug spawn positions for the BugFest playfield. Once per spawn period, measured in frame ticks, it takes a 5-bit position from a free-running LFSR, reduces it into range, and presents it with a valid flag. It also drives the select line of the downstream 5-bit 2:1 position mux. `sel = 1` steers the spawn position onto the shared position bus; `sel = 0` returns the bus to the player/cursor position.

---
 rtl/bug_spawn_gen.sv | 128 ++++++++++++
 tb/tb_bug_spawn_gen.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bug_spawn_gen.sv
// Spawn-position generator: a free-running LFSR sampled once per spawn period, range-reduced and held with a valid/select flag.
// Optional macro SPAWN_SPEEDUP_EN shortens the period by one tick every 8 acknowledges, down to a floor of 8.
module bug_spawn_gen #(
    parameter int         SPAWN_PERIOD = 60,
    parameter logic [4:0] SEED         = 5'b10101,
    parameter int         MAX_POS      = 19
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       stop,
    input  logic       ack,
    output logic [4:0] pos,
    output logic       pos_valid,
    output logic       sel
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_PRESENT} state_t;

    localparam logic [4:0] SEED_INIT  = (SEED == 5'd0) ? 5'd1 : SEED;
    localparam logic [4:0] MAX_POS_V  = 5'(MAX_POS);
    localparam logic [4:0] POS_OFFSET = 5'(MAX_POS + 1);
    localparam logic [7:0] PERIOD_V   = 8'(SPAWN_PERIOD);

    state_t     state, state_next;
    logic [4:0] lfsr;
    logic [4:0] reduced;
    logic [4:0] pos_next;
    logic [7:0] cnt, cnt_next;
    logic [7:0] reload;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            lfsr <= SEED_INIT;
        else
            lfsr <= {lfsr[3:0], lfsr[4] ^ lfsr[2]};
    end

    // A single subtraction suffices because MAX_POS+1 > 31-(MAX_POS+1) never leaves the raw value out of range by more than one step.
    assign reduced = (lfsr > MAX_POS_V) ? (lfsr - POS_OFFSET) : lfsr;

`ifdef SPAWN_SPEEDUP_EN
    logic [7:0] eff_period, eff_period_next;
    logic [2:0] spawn_cnt;
    logic       ack_taken;

    assign ack_taken = (state == S_PRESENT) && !stop && ack;

    always_comb begin
        eff_period_next = eff_period;
        if (ack_taken && (spawn_cnt == 3'd7) && (SPAWN_PERIOD >= 8) && (eff_period > 8'd8))
            eff_period_next = eff_period - 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            eff_period <= PERIOD_V;
            spawn_cnt  <= 3'd0;
        end else if (state_next == S_IDLE) begin
            eff_period <= PERIOD_V;
            spawn_cnt  <= 3'd0;
        end else begin
            eff_period <= eff_period_next;
            if (ack_taken)
                spawn_cnt <= spawn_cnt + 3'd1;
        end
    end

    // The acknowledge that wraps the spawn counter already loads the shortened period.
    assign reload = eff_period_next - 8'd1;
`else
    assign reload = PERIOD_V - 8'd1;
`endif

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        pos_next   = pos;
        case (state)
            S_IDLE: begin
                if (!stop && start) begin
                    cnt_next   = reload;
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (frame_tick) begin
                    if (cnt == 8'd0) begin
                        pos_next   = reduced;
                        state_next = S_PRESENT;
                    end else begin
                        cnt_next = cnt - 8'd1;
                    end
                end
            end
            S_PRESENT: begin
                if (stop) begin
                    state_next = S_IDLE;
                end else if (ack) begin
                    cnt_next   = reload;
                    state_next = S_WAIT;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Valid and select are registered copies of "next state is PRESENT", so they move on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= 8'd0;
            pos       <= 5'd0;
            pos_valid <= 1'b0;
            sel       <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= cnt_next;
            pos       <= pos_next;
            pos_valid <= (state_next == S_PRESENT);
            sel       <= (state_next == S_PRESENT);
        end
    end

endmodule

// File: tb/tb_bug_spawn_gen.sv
// Directed bench for bug_spawn_gen: vector table for the handshake flow plus hand sequences for LFSR, range, reset and speedup.
module tb_bug_spawn_gen;

`ifdef SPAWN_SPEEDUP_EN
    localparam int P = 10;
`else
    localparam int P = 4;
`endif
    localparam logic [4:0] SEED = 5'b10101;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       ack = 1'b0;
    logic [4:0] pos;
    logic       pos_valid;
    logic       sel;

    int errors = 0;
    int checks = 0;

    logic [4:0] m_lfsr;

    typedef struct {
        logic  start;
        logic  stop;
        logic  ack;
        logic  tick;
        int    reps;
        logic  exp_valid;
        string name;
    } vec_t;

    vec_t vecs[$];

    bug_spawn_gen #(
        .SPAWN_PERIOD(P),
        .SEED        (SEED),
        .MAX_POS     (19)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .frame_tick(frame_tick),
        .start     (start),
        .stop      (stop),
        .ack       (ack),
        .pos       (pos),
        .pos_valid (pos_valid),
        .sel       (sel)
    );

    always #5 clk = ~clk;

    // Reference LFSR, stepped with the documented feedback rule.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            m_lfsr <= SEED;
        else
            m_lfsr <= {m_lfsr[3:0], m_lfsr[4] ^ m_lfsr[2]};
    end

    function automatic logic [4:0] reduce_pos(input logic [4:0] v);
        if (v > 5'd19)
            return v - 5'd20;
        return v;
    endfunction

    task automatic check_val(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic checkOutput(input string name, input logic exp_valid,
                               input logic check_pos, input logic [4:0] exp_pos);
        checks++;
        if (pos_valid !== exp_valid) begin
            errors++;
            $display("[TB] FAIL %s pos_valid: got %0b, expected %0b", name, pos_valid, exp_valid);
        end
        checks++;
        if (sel !== exp_valid) begin
            errors++;
            $display("[TB] FAIL %s sel: got %0b, expected %0b", name, sel, exp_valid);
        end
        if (check_pos) begin
            checks++;
            if (pos !== exp_pos) begin
                errors++;
                $display("[TB] FAIL %s pos: got %0d, expected %0d", name, pos, exp_pos);
            end
        end
    endtask

    // Called at a negedge; drives one cycle of inputs and returns at the next negedge.
    task automatic applyStimulus(input logic s, input logic st, input logic a, input logic t,
                                 output logic [4:0] lfsr_seen);
        start      = s;
        stop       = st;
        ack        = a;
        frame_tick = t;
        lfsr_seen  = m_lfsr;
        @(negedge clk);
        start      = 1'b0;
        stop       = 1'b0;
        ack        = 1'b0;
        frame_tick = 1'b0;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic add_vec(input logic s, input logic st, input logic a, input logic t,
                           input int reps, input logic ev, input string name);
        vec_t v;
        v.start = s; v.stop = st; v.ack = a; v.tick = t;
        v.reps = reps; v.exp_valid = ev; v.name = name;
        vecs.push_back(v);
    endtask

    task automatic wait_for_lfsr(input logic [4:0] target, input string name);
        logic [4:0] seen;
        int n;
        n = 0;
        while (m_lfsr != target && n < 40) begin
            applyStimulus(0, 0, 0, 0, seen);
            n++;
        end
        if (m_lfsr != target) begin
            errors++;
            $display("[TB] FAIL %s: lfsr never reached %0d (now %0d)", name, target, m_lfsr);
        end
    endtask

    initial begin
        logic [4:0] seen;
        logic [4:0] exp_pos;
        logic       prev_valid;
        int         n;

        // Reset state and LFSR start-up sequence
        repeat (2) @(negedge clk);
        checkOutput("reset_outputs", 1'b0, 1'b1, 5'd0);
        rst_n = 1'b1;
        check_val("lfsr_seed", int'(dut.lfsr), 5'b10101);
        @(negedge clk);
        check_val("lfsr_step1", int'(dut.lfsr), 5'b01010);
        @(negedge clk);
        check_val("lfsr_step2", int'(dut.lfsr), 5'b10100);
        checkOutput("outputs_after_release", 1'b0, 1'b1, 5'd0);

        // Handshake flow as a vector table
        add_vec(0, 0, 0, 1, 2,     0, "tick_before_start");
        add_vec(1, 0, 0, 0, 1,     0, "start");
        add_vec(0, 0, 0, 1, P - 1, 0, "wait_ticks");
        add_vec(0, 0, 0, 1, 1,     1, "spawn1");
        add_vec(0, 0, 0, 0, 10,    1, "hold_no_ack");
        add_vec(0, 0, 1, 1, 1,     0, "ack_with_tick");
        add_vec(0, 0, 0, 1, 1,     0, "wait_a");
        add_vec(0, 0, 1, 0, 1,     0, "ack_in_wait");
        add_vec(0, 0, 0, 1, P - 3, 0, "wait_b");
        add_vec(0, 0, 1, 1, 1,     0, "ack_tick_in_wait");
        add_vec(0, 0, 0, 1, 1,     1, "spawn2");
        add_vec(1, 0, 0, 1, 2,     1, "start_in_present");
        add_vec(0, 0, 1, 0, 3,     0, "ack_held");
        add_vec(0, 0, 0, 1, P - 1, 0, "wait_c");
        add_vec(0, 0, 0, 1, 1,     1, "spawn3");
        add_vec(0, 1, 1, 0, 1,     0, "stop_over_ack");
        add_vec(0, 0, 0, 1, 2 * P, 0, "idle_ticks");
        add_vec(1, 1, 0, 0, 1,     0, "start_with_stop");
        add_vec(0, 0, 0, 1, P,     0, "idle_ticks2");
        add_vec(1, 0, 0, 0, 1,     0, "restart");
        add_vec(0, 0, 0, 1, P - 1, 0, "wait_d");
        add_vec(0, 0, 0, 1, 1,     1, "spawn4");
        add_vec(0, 1, 0, 1, 1,     0, "stop_in_present");
        add_vec(0, 0, 0, 1, P,     0, "ticks_after_stop");
        add_vec(1, 0, 0, 0, 1,     0, "restart2");
        add_vec(0, 0, 0, 1, 1,     0, "wait_e");
        add_vec(0, 1, 0, 0, 1,     0, "stop_in_wait");
        add_vec(0, 0, 0, 1, P,     0, "ticks_after_stop2");

        reset_dut();
        prev_valid = 1'b0;
        exp_pos    = 5'd0;
        foreach (vecs[i]) begin
            for (int r = 0; r < vecs[i].reps; r++) begin
                applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].ack, vecs[i].tick, seen);
                if (vecs[i].exp_valid && !prev_valid)
                    exp_pos = reduce_pos(seen);
                checkOutput(vecs[i].name, vecs[i].exp_valid, vecs[i].exp_valid, exp_pos);
                prev_valid = vecs[i].exp_valid;
            end
        end

        // Range reduction at the extremes of the LFSR sequence
        reset_dut();
        applyStimulus(1, 0, 0, 0, seen);
        repeat (P - 1) applyStimulus(0, 0, 0, 1, seen);
        wait_for_lfsr(5'b11111, "wait_lfsr_31");
        applyStimulus(0, 0, 0, 1, seen);
        checkOutput("range_31", 1'b1, 1'b1, 5'd11);
        applyStimulus(0, 0, 1, 0, seen);
        repeat (P - 1) applyStimulus(0, 0, 0, 1, seen);
        wait_for_lfsr(5'b10011, "wait_lfsr_19");
        applyStimulus(0, 0, 0, 1, seen);
        checkOutput("range_19", 1'b1, 1'b1, 5'd19);

        // Asynchronous reset while presenting, then while waiting
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_present", 1'b0, 1'b1, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1, 0, 0, 0, seen);
        repeat (2) applyStimulus(0, 0, 0, 1, seen);
        #2 rst_n = 1'b0;
        #1 checkOutput("async_reset_wait", 1'b0, 1'b1, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(0, 0, 0, 1, seen);
        checkOutput("no_spawn_after_reset", 1'b0, 1'b0, 5'd0);
        applyStimulus(1, 0, 0, 0, seen);
        repeat (P - 1) applyStimulus(0, 0, 0, 1, seen);
        checkOutput("full_period_after_reset", 1'b0, 1'b0, 5'd0);
        applyStimulus(0, 0, 0, 1, seen);
        checkOutput("spawn_after_reset", 1'b1, 1'b1, reduce_pos(seen));

`ifdef SPAWN_SPEEDUP_EN
        // Period shrinks by one every 8 acknowledges, floored at 8
        reset_dut();
        applyStimulus(1, 0, 0, 0, seen);
        for (int a = 0; a <= 40; a++) begin
            n = 0;
            while (!pos_valid && n <= 20) begin
                applyStimulus(0, 0, 0, 1, seen);
                n++;
            end
            check_val($sformatf("period_after_%0d_acks", a), n,
                      ((10 - a / 8) < 8) ? 8 : (10 - a / 8));
            applyStimulus(0, 0, 1, 0, seen);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
